// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read port,
// occupancy count, almost-full/almost-empty thresholds and overflow/underflow pulses.
module fifo_sync_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 4,
   parameter int FWFT     = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     w_en,
   input  logic [WIDTH-1:0]         d_in,
   input  logic                     r_en,
   output logic [WIDTH-1:0]         d_out,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              rd_acc;
   logic              wr_acc;
   logic              mem_wr;
   logic              mem_rd;
   logic [CNT_W-1:0]  count_nxt;

   assign rd_acc = r_en && !empty;
   // A full FIFO still takes a write when a read frees a slot on the same edge.
   assign wr_acc = w_en && (!full || rd_acc);

   always_comb begin
      count_nxt = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count        <= '0;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         count        <= count_nxt;
         full         <= (count_nxt == CNT_W'(DEPTH));
         almost_full  <= (count_nxt >= CNT_W'(AF_LEVEL));
         almost_empty <= (count_nxt <= CNT_W'(AE_LEVEL));
         overflow     <= w_en && !wr_acc;
         underflow    <= r_en && !rd_acc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (mem_wr) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (mem_rd) rd_ptr <= rd_ptr + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (mem_wr) mem[wr_ptr] <= d_in;
   end

   generate
      if (FWFT == 0) begin : g_std
         logic empty_r;

         assign mem_wr = wr_acc;
         assign mem_rd = rd_acc;
         assign empty  = empty_r;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               d_out   <= '0;
               empty_r <= 1'b1;
            end else begin
               empty_r <= (count_nxt == '0);
               if (rd_acc) d_out <= mem[rd_ptr];
            end
         end
      end else begin : g_fwft
         // d_out is the head register; memory holds everything behind it.
         logic head_valid;
         logic mem_nz;
         logic head_take;

         assign mem_nz    = (count != {{ADDR_W{1'b0}}, head_valid});
         assign head_take = !head_valid || rd_acc;
         assign mem_rd    = head_take && mem_nz;
         // With nothing queued behind the head, a write bypasses memory into d_out.
         assign mem_wr    = wr_acc && !(head_take && !mem_nz);
         assign empty     = !head_valid;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               d_out      <= '0;
               head_valid <= 1'b0;
            end else if (head_take) begin
               if (mem_nz) begin
                  d_out      <= mem[rd_ptr];
                  head_valid <= 1'b1;
               end else if (wr_acc) begin
                  d_out      <= d_in;
                  head_valid <= 1'b1;
               end else begin
                  head_valid <= 1'b0;
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: one standard-read instance and one FWFT instance,
// 8-bit x 16 deep, almost-full at 12, almost-empty at 4.
module tb_fifo_sync_param;

   logic       clk;
   logic       rst;

   logic       w0, r0;
   logic [7:0] d0, q0;
   logic       full0, empty0, af0, ae0, ovf0, unf0;
   logic [4:0] cnt0;

   logic       w1, r1;
   logic [7:0] d1, q1;
   logic       full1, empty1, af1, ae1, ovf1, unf1;
   logic [4:0] cnt1;

   int         checks;
   int         errors;
   logic [7:0] mq[$];
   logic [7:0] exp_d;
   bit         do_w, do_r, rd_ok, wr_ok;

   fifo_sync_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .w_en(w0), .d_in(d0), .r_en(r0), .d_out(q0),
      .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
      .count(cnt0), .overflow(ovf0), .underflow(unf0)
   );

   fifo_sync_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .w_en(w1), .d_in(d1), .r_en(r1), .d_out(q1),
      .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
      .count(cnt1), .overflow(ovf1), .underflow(unf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      w0 = 1'b0; r0 = 1'b0; d0 = 8'h00;
      w1 = 1'b0; r1 = 1'b0; d1 = 8'h00;
      tick();
      tick();

      chk("rst_empty", empty0, 1'b1);
      chk("rst_full", full0, 1'b0);
      chk("rst_count", cnt0, 5'd0);
      chk("rst_dout", q0, 8'h00);
      chk("rst_ae", ae0, 1'b1);
      chk("rst_af", af0, 1'b0);
      chk("rst_ovf", ovf0, 1'b0);
      chk("rst_unf", unf0, 1'b0);
      chk("rst_fwft_empty", empty1, 1'b1);
      chk("rst_fwft_count", cnt1, 5'd0);
      rst = 1'b0;
      tick();

      // fill 0x01..0x10
      for (int i = 1; i <= 16; i++) begin
         w0 = 1'b1; d0 = 8'(i);
         tick();
         chk("fill_count", cnt0, 32'(i));
         chk("fill_af", af0, (i >= 12));
         chk("fill_ae", ae0, (i <= 4));
         chk("fill_full", full0, (i == 16));
         chk("fill_empty", empty0, 1'b0);
      end
      d0 = 8'h11;
      tick();
      w0 = 1'b0;
      chk("ovf_pulse", ovf0, 1'b1);
      chk("ovf_count", cnt0, 5'd16);
      tick();
      chk("ovf_clear", ovf0, 1'b0);

      // drain
      for (int i = 1; i <= 16; i++) begin
         r0 = 1'b1;
         tick();
         chk("drain_data", q0, 32'(i));
         chk("drain_count", cnt0, 32'(16 - i));
      end
      r0 = 1'b0;
      chk("drain_empty", empty0, 1'b1);
      chk("drain_ae", ae0, 1'b1);
      r0 = 1'b1;
      tick();
      r0 = 1'b0;
      chk("unf_pulse", unf0, 1'b1);
      chk("unf_hold", q0, 8'h10);
      tick();
      chk("unf_clear", unf0, 1'b0);

      // simultaneous read/write on empty
      r0 = 1'b1; w0 = 1'b1; d0 = 8'h55;
      tick();
      r0 = 1'b0; w0 = 1'b0;
      chk("empty_rw_unf", unf0, 1'b1);
      chk("empty_rw_count", cnt0, 5'd1);
      r0 = 1'b1;
      tick();
      r0 = 1'b0;
      chk("empty_rw_data", q0, 8'h55);
      chk("empty_rw_count2", cnt0, 5'd0);

      // simultaneous read/write on full
      for (int i = 0; i < 16; i++) begin
         w0 = 1'b1; d0 = 8'(8'h20 + i);
         tick();
      end
      chk("full2_full", full0, 1'b1);
      r0 = 1'b1; w0 = 1'b1; d0 = 8'hAA;
      tick();
      w0 = 1'b0;
      chk("full_rw_count", cnt0, 5'd16);
      chk("full_rw_ovf", ovf0, 1'b0);
      chk("full_rw_data", q0, 8'h20);
      for (int k = 1; k < 16; k++) begin
         tick();
         chk("full_rw_drain", q0, 32'(8'h20 + k));
      end
      tick();
      r0 = 1'b0;
      chk("full_rw_aa", q0, 8'hAA);
      chk("full_rw_empty", empty0, 1'b1);

      // wrap-around mixed traffic vs scoreboard
      for (int i = 0; i < 40; i++) begin
         do_w = ((i % 3) != 2);
         do_r = ((i % 2) == 1);
         w0 = do_w; r0 = do_r; d0 = 8'(8'h80 + i);
         rd_ok = do_r && (mq.size() > 0);
         wr_ok = do_w && ((mq.size() < 16) || rd_ok);
         tick();
         if (rd_ok) begin
            exp_d = mq.pop_front();
            chk("wrap_data", q0, exp_d);
         end
         if (wr_ok) mq.push_back(8'(8'h80 + i));
         chk("wrap_count", cnt0, 32'(mq.size()));
      end
      w0 = 1'b0; r0 = 1'b0;

      // first-word-fall-through
      w1 = 1'b1; d1 = 8'h3C;
      tick();
      w1 = 1'b0;
      chk("fwft_head", q1, 8'h3C);
      chk("fwft_not_empty", empty1, 1'b0);
      chk("fwft_count1", cnt1, 5'd1);
      r1 = 1'b1;
      tick();
      r1 = 1'b0;
      chk("fwft_pop_empty", empty1, 1'b1);
      chk("fwft_pop_count", cnt1, 5'd0);
      for (int i = 0; i < 8; i++) begin
         w1 = 1'b1; d1 = 8'(8'h40 + i);
         tick();
      end
      w1 = 1'b0;
      chk("fwft_count8", cnt1, 5'd8);
      chk("fwft_head8", q1, 8'h40);
      r1 = 1'b1;
      tick();
      r1 = 1'b0;
      chk("fwft_next", q1, 8'h41);
      chk("fwft_count7", cnt1, 5'd7);
      tick();
      chk("fwft_hold", q1, 8'h41);

      rst = 1'b1;
      #1;
      chk("fwft_rst_count", cnt1, 5'd0);
      chk("fwft_rst_empty", empty1, 1'b1);
      chk("fwft_rst_dout", q1, 8'h00);
      tick();
      rst = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
